// File: rtl/vedic_maths2_if.sv
// Operand/product bundle for the 3x3 Vedic multiplier.
// The master drives the operands; the slave returns the registered product.
interface vedic_maths2_if;
  logic [2:0] a;
  logic [2:0] b;
  logic [5:0] ans;

  modport master (output a, output b, input ans);
  modport slave  (input a, input b, output ans);
endinterface

// File: rtl/vedic_maths2.sv
// Unsigned 3x3 Urdhva-Tiryagbhyam multiplier with a registered 6-bit product.
// Crosswise columns are reduced with explicit half/full adder cells.
module vedic_maths2 (
  input  logic           clk,
  input  logic           rst,
  vedic_maths2_if.slave  bus
);

  // Each cell returns {carry, sum}.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    half_add = {x & y, x ^ y};
  endfunction

  function automatic logic [1:0] full_add(input logic x, input logic y, input logic z);
    full_add = {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

  logic [2:0] a;
  logic [2:0] b;
  logic [5:0] s;
  logic [1:0] col1;
  logic [1:0] col2_fa;
  logic [1:0] col2_ha;
  logic [1:0] col3_fa;
  logic [1:0] col3_ha;
  logic [1:0] col4_fa;
  logic [5:0] ans_p0;

  assign a = bus.a;
  assign b = bus.b;

  // Column 2 can emit two carries, and so can column 3; column 4 absorbs both
  // plus p22 in one full adder whose carry is the product MSB.
  always_comb begin
    col1    = half_add(a[1] & b[0], a[0] & b[1]);
    col2_fa = full_add(a[2] & b[0], a[1] & b[1], a[0] & b[2]);
    col2_ha = half_add(col2_fa[0], col1[1]);
    col3_fa = full_add(a[2] & b[1], a[1] & b[2], col2_fa[1]);
    col3_ha = half_add(col3_fa[0], col2_ha[1]);
    col4_fa = full_add(a[2] & b[2], col3_fa[1], col3_ha[1]);
    s       = {col4_fa[1], col4_fa[0], col3_ha[0], col2_ha[0], col1[0], a[0] & b[0]};
  end

  // Stage p0: product register
  always_ff @(posedge clk) begin
    if (rst) begin
      ans_p0 <= 6'd0;
    end else begin
      ans_p0 <= s;
    end
  end

  assign bus.ans = ans_p0;

endmodule

// File: tb/tb_vedic_maths2.sv
// Directed bench for vedic_maths2: reset, exhaustive sweep, carry stress,
// mid-stream reset and between-edge operand changes.
module tb_vedic_maths2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  vedic_maths2_if bus ();

  vedic_maths2 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [5:0] expv);
    n_checks++;
    assert (bus.ans === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, bus.ans, expv);
    end
  endtask

  task automatic chk_bit(input string tag, input int k, input logic expv);
    n_checks++;
    assert (bus.ans[k] === expv)
    else begin
      n_fail++;
      $error("FAIL %s bit%0d observed=%b expected=%b", tag, k, bus.ans[k], expv);
    end
  endtask

  // Apply operands and reset level, then land 1 time unit after the edge.
  task automatic cycle(input logic [2:0] x, input logic [2:0] y, input logic r);
    bus.a = x;
    bus.b = y;
    rst   = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] pat;
    bus.a = 3'd7;
    bus.b = 3'd7;

    cycle(3'd7, 3'd7, 1'b1);
    chk("reset_edge1", 6'd0);
    cycle(3'd7, 3'd7, 1'b1);
    chk("reset_edge2", 6'd0);
    cycle(3'd7, 3'd7, 1'b0);
    chk("reset_release_7x7", 6'd49);

    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        cycle(i[2:0], j[2:0], 1'b0);
        chk($sformatf("sweep_%0dx%0d", i, j), 6'(i * j));
      end
    end

    cycle(3'd1, 3'd1, 1'b0); chk("spot_1x1", 6'd1);
    cycle(3'd3, 3'd5, 1'b0); chk("spot_3x5", 6'd15);
    cycle(3'd6, 3'd7, 1'b0); chk("spot_6x7", 6'd42);
    cycle(3'd0, 3'd7, 1'b0); chk("zero_a", 6'd0);
    cycle(3'd5, 3'd0, 1'b0); chk("zero_b", 6'd0);
    cycle(3'd7, 3'd1, 1'b0); chk("ones_x1", 6'd7);

    cycle(3'd7, 3'd7, 1'b0);
    pat = 6'b110001;
    for (int k = 0; k < 6; k++) chk_bit("carry_7x7", k, pat[k]);
    cycle(3'd6, 3'd6, 1'b0);
    pat = 6'b100100;
    for (int k = 0; k < 6; k++) chk_bit("carry_6x6", k, pat[k]);
    cycle(3'd7, 3'd5, 1'b0);
    pat = 6'b100011;
    for (int k = 0; k < 6; k++) chk_bit("carry_7x5", k, pat[k]);

    cycle(3'd3, 3'd3, 1'b0); chk("midrst_3x3", 6'd9);
    cycle(3'd4, 3'd5, 1'b1); chk("midrst_4x5", 6'd0);
    cycle(3'd7, 3'd6, 1'b0); chk("midrst_7x6", 6'd42);

    bus.a = 3'd1; bus.b = 3'd1;
    #2; chk("hold_change1", 6'd42);
    bus.a = 3'd6; bus.b = 3'd5;
    #2; chk("hold_change2", 6'd42);
    bus.a = 3'd3; bus.b = 3'd2;
    @(posedge clk); #1;
    chk("edge_value_3x2", 6'd6);

    rst = 1'b1;
    #2; chk("async_rst_ignored", 6'd6);
    @(posedge clk); #1;
    chk("sync_rst_applied", 6'd0);
    cycle(3'd5, 3'd5, 1'b0); chk("after_rst_5x5", 6'd25);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
